nand_share_arb: RTL and testbench
=================================

# nand_share_arb

Round-robin arbiter and sequencer that shares one N-input, D-bit NAND unit among R requesters. Each requester presents N operands; the block grants one requester, captures its operands, drives them through the bitwise NAND (o = ~(AND of all N operands, per bit)), and returns the registered result to that requester under a valid/ack handshake. It sits between the CPU-side logic clients and the single shared NAND datapath in the Hack logic layer.

## Interface
- R, 4: number of requesters (R >= 2)
- N, 2: operands per request (N >= 2)
- D, 16: operand/result bit width
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req  in  R  per-requester request, level; operands valid while high
- i_opnd  in  R x N x D  operands, indexed [requester][operand]
- o_gnt  out  R  one-hot grant pulse, one cycle; operands sampled that cycle
- o_rsp_valid  out  R  one-hot; result for that requester is on o_rsp_data
- o_rsp_data  out  D  NAND result, held stable while any o_rsp_valid bit is high
- i_rsp_ack  in  R  per-requester response acknowledge
- o_busy  out  1  high in EXEC and RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any i_req bit set, pick winner by round robin: search from (ptr+1) mod R upward, wrapping; first set bit wins. o_gnt[winner]=1 combinationally this cycle; operands of winner and winner index registered; next state EXEC. No request: stay IDLE, o_gnt=0.
- EXEC: registered operands drive the NAND unit; result registered into o_rsp_data; next state RESP.
- RESP: o_rsp_valid[owner]=1. When i_rsp_ack[owner]=1: ptr<=owner, clear valid, next state IDLE. Ack bits of non-owners ignored; ack while not in RESP ignored.
- Granted requester must drop or refresh i_req after o_gnt; a still-high i_req is treated as a new request in the next IDLE.
- i_req/i_opnd changes after grant have no effect on the in-flight operation.
- Fairness: after serving requester k, k has lowest priority in the next arbitration; with all R requesting continuously, service order is cyclic.
- Reset (any cycle, including mid-EXEC/RESP): state IDLE, ptr=R-1 (requester 0 highest priority first), o_gnt=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0; in-flight operation abandoned, no response produced.

## Timing
- Grant in cycle t (IDLE) -> o_rsp_valid high from cycle t+2.
- Ack in cycle t+2 (same cycle valid first high) -> IDLE at t+3, next grant possible at t+3.
- Minimum issue interval 3 cycles; no pipelining, one operation in flight.
- Ack latency unbounded; block stalls in RESP, o_rsp_data and o_rsp_valid held.
- o_gnt is the only combinational output (from state and i_req); all others registered.

## Structure
- Shared package nand_share_pkg: FSM state enum typedef (IDLE, EXEC, RESP), reset value constants.
- Sub-module rr_picker: parameter R; inputs request vector and ptr; output one-hot winner and binary index. Pure combinational, reused by other Hack-layer arbiters.
- NAND datapath is the team's existing N-input D-bit NAND unit, instantiated once; ptr width $clog2(R).

## Test plan
- Reset then i_req=0001, i_opnd[0]={FFFF,00FF} -> o_gnt=0001 same cycle, o_rsp_valid=0001 two cycles later, o_rsp_data=FF00; ack -> IDLE next cycle.
- All four requesting continuously, ack immediately -> grants 0001,0010,0100,1000,0001 at 3-cycle spacing.
- After serving requester 2, i_req=0101 -> grant 0001 (search starts at 3, wraps to 0).
- Response pending, ack withheld 10 cycles, non-owner acks pulsed, i_opnd changed -> o_rsp_data and o_rsp_valid unchanged until owner ack.
- i_rst_n low during EXEC -> next cycle all outputs 0, no o_rsp_valid; after release, requester 0 wins a full-request tie.
- N=3, D=16, operands {FFFF,FFFF,FFFF} -> 0000; {0000,FFFF,FFFF} -> FFFF.

Source files
------------

// File: rtl/nand_share_pkg.sv
// Shared types and reset constants for the NAND-sharing arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nand_share_pkg;

    // Sequencer phases: arbitrate, compute, hold response until acked.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam state_t STATE_RST = IDLE;

    // The round-robin pointer resets to the last requester so that the
    // first search after reset starts at requester 0.
    function automatic int ptr_rst(input int r);
        return r - 1;
    endfunction

endpackage

// File: rtl/nand_share_arb_if.sv
// Requester-side bundle for nand_share_arb: requests, operands, grant, response.
// Latency: n/a (wiring only).
// Backpressure: response held until the owner's i_rsp_ack bit is seen.
// Ports: i_req/i_opnd/i_rsp_ack from requesters; o_gnt/o_rsp_valid/o_rsp_data/o_busy back.
interface nand_share_arb_if #(
    parameter int R = 4,
    parameter int N = 2,
    parameter int D = 16
);
    logic [R-1:0]                 i_req;
    logic [R-1:0][N-1:0][D-1:0]   i_opnd;
    logic [R-1:0]                 o_gnt;
    logic [R-1:0]                 o_rsp_valid;
    logic [D-1:0]                 o_rsp_data;
    logic [R-1:0]                 i_rsp_ack;
    logic                         o_busy;

    // Requester side
    modport master (
        output i_req, i_opnd, i_rsp_ack,
        input  o_gnt, o_rsp_valid, o_rsp_data, o_busy
    );

    // Arbiter side
    modport slave (
        input  i_req, i_opnd, i_rsp_ack,
        output o_gnt, o_rsp_valid, o_rsp_data, o_busy
    );
endinterface

// File: rtl/nand_unit.sv
// N-input, D-bit bitwise NAND: res = ~(opnd[0] & ... & opnd[N-1]).
// Latency: combinational.
// Backpressure: none.
// Ports: opnd (N x D operands) -> res (D bits).
module nand_unit #(
    parameter int N = 2,
    parameter int D = 16
) (
    input  logic [N-1:0][D-1:0] opnd,
    output logic [D-1:0]        res
);
    logic [D-1:0] acc;

    always_comb begin
        acc = '1;
        for (int i = 0; i < N; i++) begin
            acc = acc & opnd[i];
        end
        res = ~acc;
    end
endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first set request bit searching upward from ptr+1, wrapping.
// Latency: combinational.
// Backpressure: none; any=0 when no bit is set.
// Ports: req (request vector), ptr (last served) -> win_onehot, win_idx, any.
module rr_picker #(
    parameter int R  = 4,
    parameter int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [R-1:0]  win_onehot,
    output logic [PW-1:0] win_idx,
    output logic          any
);
    int  j;
    logic found;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        j          = 0;
        // Offset 1..R so the last-served requester is checked last.
        for (int i = 1; i <= R; i++) begin
            j = (int'(ptr) + i) % R;
            if (!found && req[j]) begin
                found         = 1'b1;
                win_onehot[j] = 1'b1;
                win_idx       = PW'(j);
            end
        end
        any = found;
    end
endmodule

// File: rtl/nand_share_arb.sv
// Round-robin sharing of one NAND unit among R requesters, one op in flight.
// Latency: grant cycle t -> o_rsp_valid from t+2; min issue interval 3 cycles.
// Backpressure: stalls in RESP with data/valid held until the owner acks.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave side of nand_share_arb_if).
module nand_share_arb
    import nand_share_pkg::*;
#(
    parameter int R = 4,
    parameter int N = 2,
    parameter int D = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    nand_share_arb_if.slave  bus
);
    localparam int PW = (R > 1) ? $clog2(R) : 1;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        owner_q;
    logic [N-1:0][D-1:0]  opnd_q;
    logic [D-1:0]         rsp_data_q;
    logic [R-1:0]         rsp_valid_q;

    logic [R-1:0]         win_onehot;
    logic [PW-1:0]        win_idx;
    logic                 win_any;
    logic [D-1:0]         nand_res;
    logic [R-1:0]         gnt;
    logic                 take;
    logic                 owner_ack;

    rr_picker #(.R(R), .PW(PW)) u_picker (
        .req        (bus.i_req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (win_any)
    );

    nand_unit #(.N(N), .D(D)) u_nand (
        .opnd (opnd_q),
        .res  (nand_res)
    );

    // Only the owner's ack matters; everything else on i_rsp_ack is ignored.
    assign owner_ack = bus.i_rsp_ack[owner_q];

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt     = win_onehot;
                    take    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (owner_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= STATE_RST;
            ptr_q       <= PW'(ptr_rst(R));
            owner_q     <= '0;
            opnd_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                // Operands are captured here so later i_opnd changes are inert.
                opnd_q  <= bus.i_opnd[win_idx];
                owner_q <= win_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q  <= nand_res;
                rsp_valid_q <= R'(1) << owner_q;
            end
            if (state_q == RESP && owner_ack) begin
                ptr_q       <= owner_q;
                rsp_valid_q <= '0;
            end
        end
    end

    assign bus.o_gnt       = gnt;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_nand_share_arb.sv
// Self-checking bench for nand_share_arb: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: randomized acks exercise RESP stalls.
module tb_nand_share_arb;
    localparam int R = 4;
    localparam int N = 2;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nand_share_arb_if #(.R(R), .N(N), .D(D)) bus ();
    nand_share_arb_if #(.R(R), .N(3), .D(D)) bus3 ();

    nand_share_arb #(.R(R), .N(N), .D(D)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    nand_share_arb #(.R(R), .N(3), .D(D)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus3.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [R-1:0] gnt_log[$];

    // Reference model: timeline of the single in-flight operation.
    bit           m_idle  = 1'b1;
    int           m_last  = R - 1;
    int           m_owner = 0;
    int           m_gcyc  = 0;
    logic [D-1:0] m_res   = '0;
    logic [D-1:0] m_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // A result bit is 1 unless every operand has a 1 in that position.
    function automatic logic [D-1:0] nand_ref(input logic [N-1:0][D-1:0] ops);
        logic [D-1:0] r;
        for (int b = 0; b < D; b++) begin
            int ones;
            ones = 0;
            for (int i = 0; i < N; i++) if (ops[i][b]) ones++;
            r[b] = (ones != N);
        end
        return r;
    endfunction

    task automatic model_cycle();
        logic [R-1:0] eg;
        logic [R-1:0] ev;
        int w;
        eg = '0;
        ev = '0;
        w  = -1;
        if (!rst_n) begin
            m_idle = 1'b1;
            m_last = R - 1;
            m_data = '0;
        end else begin
            if (m_idle) begin
                for (int off = 1; off <= R; off++) begin
                    int k;
                    k = (m_last + off) % R;
                    if (w < 0 && bus.i_req[k]) w = k;
                end
                if (w >= 0) eg[w] = 1'b1;
            end
            if (!m_idle && cyc >= m_gcyc + 2) ev[m_owner] = 1'b1;
            check("gnt", 32'(bus.o_gnt), 32'(eg));
            check("rsp_valid", 32'(bus.o_rsp_valid), 32'(ev));
            check("busy", 32'(bus.o_busy), 32'(!m_idle));
            check("rsp_data", 32'(bus.o_rsp_data), 32'(m_data));
            if (bus.o_gnt != '0) gnt_log.push_back(bus.o_gnt);
            if (!m_idle && cyc == m_gcyc + 1) m_data = m_res;
            if (w >= 0) begin
                m_idle  = 1'b0;
                m_owner = w;
                m_gcyc  = cyc;
                m_res   = nand_ref(bus.i_opnd[w]);
            end else if (!m_idle && cyc >= m_gcyc + 2 && bus.i_rsp_ack[m_owner]) begin
                m_idle = 1'b1;
                m_last = m_owner;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic op3(input string tag, input logic [D-1:0] a, input logic [D-1:0] b,
                       input logic [D-1:0] c, input logic [D-1:0] exp);
        bus3.i_opnd[0][0] = a;
        bus3.i_opnd[0][1] = b;
        bus3.i_opnd[0][2] = c;
        bus3.i_req = 4'b0001;
        step();
        bus3.i_req = '0;
        step();
        check({tag, "_vld"}, 32'(bus3.o_rsp_valid), 32'h1);
        check(tag, 32'(bus3.o_rsp_data), 32'(exp));
        bus3.i_rsp_ack = 4'b0001;
        step();
        bus3.i_rsp_ack = '0;
        step();
    endtask

    initial begin
        logic [R-1:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus.i_req = '0;  bus.i_opnd = '0;  bus.i_rsp_ack = '0;
        bus3.i_req = '0; bus3.i_opnd = '0; bus3.i_rsp_ack = '0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Single op from requester 0: ~(FFFF & 00FF) = FF00.
        bus.i_req = 4'b0001;
        bus.i_opnd[0][1] = 16'hFFFF;
        bus.i_opnd[0][0] = 16'h00FF;
        step();
        bus.i_req = '0;
        step();
        check("t1_valid", 32'(bus.o_rsp_valid), 32'h1);
        check("t1_data", 32'(bus.o_rsp_data), 32'hFF00);
        bus.i_rsp_ack = 4'b0001;
        step();
        bus.i_rsp_ack = '0;
        step();

        // All requesting from reset with instant ack: cyclic order every 3 cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        gnt_log.delete();
        bus.i_req = '1;
        bus.i_rsp_ack = '1;
        repeat (13) begin
            bus.i_opnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        bus.i_req = '0;
        repeat (3) step();
        check("order_cnt", 32'(gnt_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'h0, 32'(exp_order[i]));

        // Serve requester 2, then 0101 must wrap around to requester 0.
        gnt_log.delete();
        bus.i_req = 4'b0100;
        bus.i_rsp_ack = 4'b0100;
        step();
        bus.i_req = '0;
        step();
        step();
        bus.i_req = 4'b0101;
        step();
        bus.i_req = '0;
        bus.i_rsp_ack = '1;
        repeat (3) step();
        check("wrap_cnt", 32'(gnt_log.size()), 32'd2);
        check("wrap_gnt", (gnt_log.size() > 1) ? 32'(gnt_log[1]) : 32'h0, 32'b0001);

        // Held response: owner 1 withholds ack, others pulse, operands churn.
        bus.i_rsp_ack = '0;
        bus.i_req = 4'b0010;
        bus.i_opnd[1][1] = 16'h1234;
        bus.i_opnd[1][0] = 16'h0F0F;
        step();
        bus.i_req = '0;
        step();
        repeat (10) begin
            bus.i_rsp_ack = 4'($urandom()) & 4'b1101;
            bus.i_opnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.i_req = 4'($urandom());
            step();
        end
        check("hold_valid", 32'(bus.o_rsp_valid), 32'b0010);
        check("hold_data", 32'(bus.o_rsp_data), 32'hFDFB);
        bus.i_req = '0;
        bus.i_rsp_ack = 4'b0010;
        step();
        bus.i_rsp_ack = '0;
        step();

        // Reset while EXEC abandons the op; then requester 0 wins the tie.
        bus.i_req = '1;
        step();
        bus.i_req = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_valid", 32'(bus.o_rsp_valid), 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_data", 32'(bus.o_rsp_data), 32'h0);
        check("rst_gnt", 32'(bus.o_gnt), 32'h0);
        step();
        gnt_log.delete();
        bus.i_req = '1;
        step();
        check("rst_tie", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'h0, 32'b0001);
        bus.i_req = '0;
        bus.i_rsp_ack = '1;
        repeat (3) step();

        // Randomized traffic with occasional resets.
        repeat (800) begin
            bus.i_req = 4'($urandom());
            bus.i_opnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.i_rsp_ack = 4'($urandom());
            rst_n = ($urandom_range(0, 63) != 0);
            step();
        end
        rst_n = 1'b1;
        bus.i_req = '0;
        bus.i_rsp_ack = '1;
        repeat (4) step();
        bus.i_rsp_ack = '0;

        // Three-operand instance.
        op3("n3_all1", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
        op3("n3_one0", 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
